// File: rtl/fir_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// fir_pkg : shared width default, load-FSM states and reset pattern
// Rev 1.0
// ---------------------------------------------------------------------
package fir_pkg;

   localparam int DEFAULT_COEFF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } load_state_e;

   // Power-on coefficient for tap idx: a descending ramp TAPS..1.
   function automatic int reset_coeff(input int taps, input int idx);
      return taps - idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/coeff_ram.sv
`default_nettype none
// ---------------------------------------------------------------------
// coeff_ram : one coefficient bank, sync write, async read, sync init
// Rev 1.0
// ---------------------------------------------------------------------
module coeff_ram
   import fir_pkg::*;
#(
   parameter int COEFF_WIDTH  = DEFAULT_COEFF_WIDTH,
   parameter int TAPS         = 8,
   parameter int ADDR_WIDTH   = $clog2(TAPS),
   parameter bit PATTERN_INIT = 1'b1
) (
   input  logic                   clock,
   input  logic                   init_i,
   input  logic                   we_i,
   input  logic [ADDR_WIDTH-1:0]  waddr_i,
   input  logic [COEFF_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0]  raddr_i,
   output logic [COEFF_WIDTH-1:0] rdata_o
);

   logic [COEFF_WIDTH-1:0] mem_q [TAPS];

   always_ff @(posedge clock) begin
      if (init_i) begin
         for (int i = 0; i < TAPS; i++) begin
            mem_q[i] <= PATTERN_INIT ? COEFF_WIDTH'(reset_coeff(TAPS, i)) : '0;
         end
      end else if (we_i && (int'(waddr_i) < TAPS)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Addresses beyond the populated taps read as zero.
   always_comb begin
      rdata_o = '0;
      if (int'(raddr_i) < TAPS) begin
         rdata_o = mem_q[raddr_i];
      end
   end

endmodule
`default_nettype wire

// File: rtl/coeff_bank.sv
`default_nettype none
// ---------------------------------------------------------------------
// coeff_bank : double-buffered, reloadable FIR coefficient store
// Rev 1.0
// ---------------------------------------------------------------------
module coeff_bank
   import fir_pkg::*;
#(
   parameter int COEFF_WIDTH = DEFAULT_COEFF_WIDTH,
   parameter int TAPS        = 8,
   parameter int ADDR_WIDTH  = $clog2(TAPS)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   en,
   input  logic [ADDR_WIDTH-1:0]  addr,
   output logic [COEFF_WIDTH-1:0] rom_out,
   input  logic                   ld_valid,
   output logic                   ld_ready,
   input  logic [COEFF_WIDTH-1:0] ld_data,
   input  logic                   ld_last,
   input  logic                   swap_req,
   output logic                   swap_done,
   output logic                   load_err,
   output logic                   active_bank,
   output logic                   shadow_full
);

   load_state_e            state_q;
   logic [ADDR_WIDTH-1:0]  wptr_q;
   logic                   active_bank_q;
   logic                   ld_ready_q;
   logic                   swap_done_q;
   logic                   load_err_q;
   logic                   shadow_full_q;
   logic [COEFF_WIDTH-1:0] rom_out_q;
   logic [COEFF_WIDTH-1:0] rom_out_d;

   logic                   w_accept;
   logic                   w_last_idx;
   logic                   w_init;
   logic [COEFF_WIDTH-1:0] w_rdata0;
   logic [COEFF_WIDTH-1:0] w_rdata1;

   assign w_accept   = ld_valid & ld_ready_q;
   assign w_last_idx = (wptr_q == ADDR_WIDTH'(TAPS - 1));
   assign w_init     = ~reset_n;

   // Loads always land in the bank that is not being read.
   coeff_ram #(
      .COEFF_WIDTH (COEFF_WIDTH),
      .TAPS        (TAPS),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .PATTERN_INIT(1'b1)
   ) u_bank0 (
      .clock  (clock),
      .init_i (w_init),
      .we_i   (w_accept & active_bank_q),
      .waddr_i(wptr_q),
      .wdata_i(ld_data),
      .raddr_i(addr),
      .rdata_o(w_rdata0)
   );

   coeff_ram #(
      .COEFF_WIDTH (COEFF_WIDTH),
      .TAPS        (TAPS),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .PATTERN_INIT(1'b0)
   ) u_bank1 (
      .clock  (clock),
      .init_i (w_init),
      .we_i   (w_accept & ~active_bank_q),
      .waddr_i(wptr_q),
      .wdata_i(ld_data),
      .raddr_i(addr),
      .rdata_o(w_rdata1)
   );

   always_comb begin
      rom_out_d = rom_out_q;
      if (en) begin
         rom_out_d = active_bank_q ? w_rdata1 : w_rdata0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rom_out_q <= '0;
      end else begin
         rom_out_q <= rom_out_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         wptr_q        <= '0;
         active_bank_q <= 1'b0;
         ld_ready_q    <= 1'b0;
         swap_done_q   <= 1'b0;
         load_err_q    <= 1'b0;
         shadow_full_q <= 1'b0;
      end else begin
         swap_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               ld_ready_q <= 1'b1;
               if (w_accept) begin
                  if (ld_last) begin
                     load_err_q <= 1'b1;
                     wptr_q     <= '0;
                  end else begin
                     wptr_q  <= ADDR_WIDTH'(1);
                     state_q <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (w_accept) begin
                  if (w_last_idx) begin
                     state_q       <= FULL;
                     ld_ready_q    <= 1'b0;
                     shadow_full_q <= 1'b1;
                  end else if (ld_last) begin
                     load_err_q <= 1'b1;
                     wptr_q     <= '0;
                     state_q    <= IDLE;
                  end else begin
                     wptr_q <= wptr_q + ADDR_WIDTH'(1);
                  end
               end
            end
            FULL: begin
               // A swap request arriving with the final word was seen in LOAD and dropped.
               if (swap_req) begin
                  active_bank_q <= ~active_bank_q;
                  swap_done_q   <= 1'b1;
                  shadow_full_q <= 1'b0;
                  wptr_q        <= '0;
                  ld_ready_q    <= 1'b1;
                  state_q       <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign rom_out     = rom_out_q;
   assign ld_ready    = ld_ready_q;
   assign swap_done   = swap_done_q;
   assign load_err    = load_err_q;
   assign active_bank = active_bank_q;
   assign shadow_full = shadow_full_q;

endmodule
`default_nettype wire

// File: tb/tb_coeff_bank.sv
`default_nettype none
// ---------------------------------------------------------------------
// tb_coeff_bank : scoreboard bench for coeff_bank (TAPS=8 and TAPS=6)
// Rev 1.0
// ---------------------------------------------------------------------
module tb_coeff_bank;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       en = 1'b0;
   logic [2:0] addr = '0;
   logic       ld_valid = 1'b0;
   logic [7:0] ld_data = '0;
   logic       ld_last = 1'b0;
   logic       swap_req = 1'b0;
   logic [7:0] rom_out;
   logic       ld_ready, swap_done, load_err, active_bank, shadow_full;

   logic       en6 = 1'b0;
   logic [2:0] addr6 = '0;
   logic [7:0] rom_out6;
   logic       ld_ready6, swap_done6, load_err6, active_bank6, shadow_full6;

   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   logic       en_d1 = 1'b0;

   always #5 clock = ~clock;

   coeff_bank #(.COEFF_WIDTH(8), .TAPS(8), .ADDR_WIDTH(3)) dut (
      .clock(clock), .reset_n(reset_n), .en(en), .addr(addr), .rom_out(rom_out),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
      .swap_req(swap_req), .swap_done(swap_done), .load_err(load_err),
      .active_bank(active_bank), .shadow_full(shadow_full)
   );

   coeff_bank #(.COEFF_WIDTH(8), .TAPS(6), .ADDR_WIDTH(3)) dut6 (
      .clock(clock), .reset_n(reset_n), .en(en6), .addr(addr6), .rom_out(rom_out6),
      .ld_valid(1'b0), .ld_ready(ld_ready6), .ld_data(8'h00), .ld_last(1'b0),
      .swap_req(1'b0), .swap_done(swap_done6), .load_err(load_err6),
      .active_bank(active_bank6), .shadow_full(shadow_full6)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   always @(posedge clock) en_d1 <= en;

   // Monitor: every enabled read produces one rom_out value a cycle later.
   always @(negedge clock) begin
      if (en_d1) begin
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            chk("rom_out", 32'(rom_out), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic rd(input int a, input logic [7:0] e_val);
      addr = 3'(a);
      en   = 1'b1;
      exp_q.push_back(e_val);
      tick();
      en = 1'b0;
   endtask

   task automatic ld(input logic [7:0] d, input logic last);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(); tick(); tick();
      chk("rst_rom_out", 32'(rom_out), 32'h0);
      chk("rst_ld_ready", 32'(ld_ready), 32'h0);
      chk("rst_active", 32'(active_bank), 32'h0);
      chk("rst_shadow_full", 32'(shadow_full), 32'h0);
      chk("rst_flags", {30'd0, swap_done, load_err}, 32'h0);
      reset_n = 1'b1;
      tick();
      chk("ready_after_rst", 32'(ld_ready), 32'h1);

      // Power-on pattern 8..1
      for (int i = 0; i < 8; i++) rd(i, 8'(8 - i));

      // Full load of 0x10..0x17
      for (int i = 0; i < 8; i++) ld(8'(8'h10 + i), i == 7);
      chk("full_shadow_full", 32'(shadow_full), 32'h1);
      chk("full_ld_ready", 32'(ld_ready), 32'h0);
      for (int i = 0; i < 8; i++) rd(i, 8'(8 - i));

      // Read during swap returns the old bank
      swap_req = 1'b1;
      rd(2, 8'd6);
      swap_req = 1'b0;
      chk("swap_done_pulse", 32'(swap_done), 32'h1);
      chk("swap_active", 32'(active_bank), 32'h1);
      chk("swap_shadow_clr", 32'(shadow_full), 32'h0);
      rd(2, 8'h12);
      chk("swap_done_low", 32'(swap_done), 32'h0);
      for (int i = 0; i < 8; i++) rd(i, 8'(8'h10 + i));

      // Early ld_last aborts the load
      ld(8'h20, 1'b0);
      ld(8'h21, 1'b0);
      ld(8'h22, 1'b1);
      chk("early_load_err", 32'(load_err), 32'h1);
      chk("early_shadow_full", 32'(shadow_full), 32'h0);
      tick();
      chk("early_err_low", 32'(load_err), 32'h0);
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      chk("early_no_swap", 32'(swap_done), 32'h0);
      chk("early_active", 32'(active_bank), 32'h1);
      for (int i = 0; i < 3; i++) rd(i, 8'(8'h10 + i));

      // Final word together with swap_req: no swap taken
      for (int i = 0; i < 7; i++) ld(8'(8'h30 + i), 1'b0);
      swap_req = 1'b1;
      ld(8'h37, 1'b1);
      swap_req = 1'b0;
      chk("coll_no_swap", 32'(swap_done), 32'h0);
      chk("coll_full", 32'(shadow_full), 32'h1);

      // Backpressure in FULL
      ld_valid = 1'b1;
      ld_data  = 8'h55;
      ld_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_ld_ready", 32'(ld_ready), 32'h0);
         chk("bp_load_err", 32'(load_err), 32'h0);
      end
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      chk("bp_swap_done", 32'(swap_done), 32'h1);
      chk("bp_active", 32'(active_bank), 32'h0);
      for (int i = 0; i < 8; i++) rd(i, 8'(8'h30 + i));

      // Second set accepted after the swap
      for (int i = 0; i < 8; i++) ld(8'(8'h40 + i), i == 7);
      chk("set2_full", 32'(shadow_full), 32'h1);
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      chk("set2_active", 32'(active_bank), 32'h1);
      for (int i = 0; i < 8; i++) rd(i, 8'(8'h40 + i));

      // Reset in the middle of a load
      for (int i = 0; i < 4; i++) ld(8'(8'h50 + i), 1'b0);
      reset_n = 1'b0;
      tick(); tick();
      chk("mid_rst_active", 32'(active_bank), 32'h0);
      chk("mid_rst_full", 32'(shadow_full), 32'h0);
      chk("mid_rst_rom", 32'(rom_out), 32'h0);
      reset_n = 1'b1;
      tick();
      chk("mid_rst_ready", 32'(ld_ready), 32'h1);
      for (int i = 0; i < 8; i++) rd(i, 8'(8 - i));
      for (int i = 0; i < 7; i++) ld(8'(8'h60 + i), 1'b0);
      chk("mid_rst_wptr_7", 32'(shadow_full), 32'h0);
      ld(8'h67, 1'b1);
      chk("mid_rst_wptr_8", 32'(shadow_full), 32'h1);
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      rd(0, 8'h60);
      rd(7, 8'h67);

      // TAPS=6 instance: out-of-range address reads zero
      en6   = 1'b1;
      addr6 = 3'd5;
      tick();
      chk("t6_addr5", 32'(rom_out6), 32'h1);
      addr6 = 3'd7;
      tick();
      chk("t6_addr7", 32'(rom_out6), 32'h0);
      addr6 = 3'd0;
      tick();
      chk("t6_addr0", 32'(rom_out6), 32'h6);
      en6 = 1'b0;

      tick(); tick();
      chk("sb_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
